// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: one CW-bit chunk per stage, carry registered
// between stages, valid/ready handshake with a single global advance enable.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = WIDTH / STAGES;

  logic             advance;

  logic             valid_d [STAGES];
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_d [STAGES];
  logic             carry_q [STAGES];
  logic             ovf_d;
  logic             ovf_q;

  // Stage inputs: index 0 is the operand port, index k+1 is the register of stage k.
  logic             p_valid [STAGES+1];
  logic [WIDTH-1:0] p_a     [STAGES+1];
  logic [WIDTH-1:0] p_b     [STAGES+1];
  logic [WIDTH-1:0] p_sum   [STAGES+1];
  logic             p_carry [STAGES+1];
  logic [CW:0]      chunk;

  always_comb begin
    advance    = !valid_q[STAGES-1] || out_ready;

    p_valid[0] = in_valid;
    p_a[0]     = a;
    p_b[0]     = b;
    p_sum[0]   = '0;
    p_carry[0] = c_in;
    for (int unsigned k = 0; k < STAGES; k++) begin
      p_valid[k+1] = valid_q[k];
      p_a[k+1]     = a_q[k];
      p_b[k+1]     = b_q[k];
      p_sum[k+1]   = sum_q[k];
      p_carry[k+1] = carry_q[k];
    end

    chunk = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk = {1'b0, p_a[k][k*CW +: CW]} + {1'b0, p_b[k][k*CW +: CW]}
            + {{CW{1'b0}}, p_carry[k]};
      valid_d[k] = valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
      if (advance) begin
        valid_d[k]              = p_valid[k];
        a_d[k]                  = p_a[k];
        b_d[k]                  = p_b[k];
        sum_d[k]                = p_sum[k];
        sum_d[k][k*CW +: CW]    = chunk[CW-1:0];
        carry_d[k]              = chunk[CW];
      end
    end

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    ovf_d = ovf_q;
    if (advance) begin
      ovf_d = carry_d[STAGES-1] ^ sum_d[STAGES-1][WIDTH-1]
            ^ p_a[STAGES-1][WIDTH-1] ^ p_b[STAGES-1][WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder with valid/ready handshakes. It is the multi-bit, clocked successor to the single-bit full adder. WIDTH-bit operands are split into STAGES equal chunks, and one chunk is added per pipeline stage, with the carry registered between stages. It sits between operand producers and result consumers that need one add per cycle at high clock rates, and it supports backpressure.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (≥1); chunk width CW = WIDTH/STAGES, must be ≥1.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  unsigned carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage k (0..STAGES-1) adds chunk k of A and B, bits [k*CW +: CW], plus the carry registered by stage k-1. Stage 0 uses c_in.
- Each stage register holds:
  - a valid bit;
  - the result chunks already computed;
  - the unconsumed upper operand chunks;
  - the outgoing carry.
- The last stage also computes overflow. Its inputs are the carry into bit WIDTH-1 and c_out, both from the final chunk addition.
- Global enable: advance = !out_valid || out_ready.
  - When advance=1, every stage register loads from its predecessor.
  - Stage 0 loads {in_valid, operands}.
  - When advance=0, all stage registers hold.
- in_ready = advance. This is combinational from out_valid and out_ready, with no dependency on in_valid.
- A beat is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- Bubbles are not collapsed. An empty stage still advances only under the global enable.
- sum, c_out and overflow are driven directly from last-stage registers. They are meaningful only while out_valid=1, and are held stable while out_valid=1 && out_ready=0.
- Data registers need not reset. Valid bits must reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - all stage valid bits clear immediately;
  - out_valid=0, so in_ready=1;
  - sum=0, c_out=0, overflow=0 (data registers also cleared, so outputs are deterministic).
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1. That is STAGES cycles from the in_valid cycle to the first out_valid cycle, with no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 → in_ready=0 in the same cycle, and no beat is lost or duplicated.
- Simultaneous accept and deliver in one cycle is legal and required at full throughput.
- Reset mid-operation: all in-flight beats are discarded, and no out_valid pulse follows the deassertion of rst_n.
- STAGES=1: a purely registered adder with latency 1 cycle.
- Carry chain: the critical path is one CW-bit add plus carry mux.

## Test plan
Unless noted, WIDTH=8, STAGES=2.
- Reset:
  - assert rst_n=0 mid-stream with 2 beats in flight → out_valid=0 and in_ready=1 immediately;
  - release reset → no out_valid for 4 cycles with in_valid=0.
- Basic carry:
  - a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, overflow=0, 2 cycles after accept;
  - a=0x0F, b=0x00, c_in=1 → sum=0x10, c_out=0.
- Signed overflow:
  - a=0x7F, b=0x01 → sum=0x80, c_out=0, overflow=1;
  - a=0x80, b=0x80 → sum=0x00, c_out=1, overflow=1;
  - a=0xFF, b=0xFF → sum=0xFE, c_out=1, overflow=0.
- Backpressure:
  - stream 6 beats (a=i, b=2i) with out_ready low on cycles 3–5;
  - required: in_ready low exactly while out_valid && !out_ready;
  - required: results 0,3,6,9,12,15 appear in order, with no loss or duplication, and sum stable during the stall.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles with random operands → 16 consecutive out_valid cycles, each matching the reference model a+b+c_in.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (32,4), (32,8), (64,2), each with 1000 random beats and random out_ready → all results match the model, and latency equals STAGES whenever there is no stall.
